tnn_sample_sequencer: RTL and testbench
=======================================

# tnn_sample_sequencer

Sequencer that feeds a combinational tiny-classifier core (four 2-bit feature inputs, one 1-bit class output) from a serial feature stream. It assembles feature vectors, presents them to the core, captures the class bit, and returns it over a valid/ready result channel. It also keeps per-batch positive/total counts and emits a one-cycle batch summary. It sits between the sample DMA/stream source and the result collector; the core itself is instantiated outside this block.

## Interface
- FEAT_W, 2, width of one feature and of each core input
- BATCH_LEN, 16, samples per batch when s_last is not seen first (1..255)
- CNT_W, 8, width of batch counters (must hold BATCH_LEN)

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous soft clear: return to COLLECT, drop partial sample and counters
- s_valid  in  1  feature beat valid
- s_ready  out  1  feature beat accepted when s_valid && s_ready
- s_data  in  FEAT_W  feature value; beats ordered a, b, c, d
- s_last  in  1  end-of-batch marker, meaningful only on the d beat
- core_a, core_b, core_c, core_d  out  FEAT_W each  registered core inputs
- core_out  in  1  core class bit (combinational from core_a..d)
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_class  out  1  captured class bit
- m_idx  out  CNT_W  sample index within current batch (0-based)
- sum_valid  out  1  one-cycle batch-summary strobe
- sum_pos  out  CNT_W  count of class==1 in finished batch
- sum_total  out  CNT_W  samples in finished batch
- err  out  1  sticky protocol error
- busy  out  1  high in EVAL or OUT, or when feature count != 0

## Operation
- States: COLLECT, EVAL, OUT. Reset state COLLECT.
- COLLECT: s_ready=1. Each accepted beat writes s_data to core_a/b/c/d per 2-bit beat counter (0..3), counter increments. Accepting beat 3 (d) latches s_last into last_q, clears beat counter, goes to EVAL.
- EVAL: s_ready=0; core inputs stable for one full cycle; at end of cycle m_class<=core_out, go to OUT.
- OUT: m_valid=1, m_class/m_idx held stable until m_ready. On handshake: if m_class==1 pos_cnt++; total_cnt++; batch ends if last_q or total_cnt+1==BATCH_LEN.
  - Batch end: next cycle sum_valid=1, sum_pos/sum_total = updated counts; pos_cnt, total_cnt, m_idx reset to 0.
  - Otherwise m_idx++.
  - Either way return to COLLECT.
- s_last high on beats a/b/c: ignored for batching, err set (sticky until rst_n or clear).
- Counters are CNT_W wide and never wrap inside a legal batch; BATCH_LEN bounds them.
- clear: same cycle effect as reset on state, counters, m_valid, sum_valid, err; core_* registers keep value. clear wins over any simultaneous handshake (that beat/result is dropped).

## Timing
- Reset values: s_ready=1, core_a..d=0, m_valid=0, m_class=0, m_idx=0, sum_valid=0, sum_pos=0, sum_total=0, err=0, busy=0.
- Minimum per-sample latency: d-beat accept cycle N → EVAL at N+1 → m_valid at N+2.
- Max throughput: 6 cycles/sample (4 COLLECT + EVAL + OUT with m_ready=1).
- sum_valid is asserted in the cycle after the final result handshake, concurrently with s_ready=1; sum_pos/sum_total hold until the next summary.
- m_ready low holds OUT indefinitely; s_ready stays 0, no beats lost.
- s_valid low mid-sample: partial vector retained, no timeout.
- rst_n assertion mid-EVAL/OUT: immediate return to reset values, result discarded.

## Test plan
- Reset: rst_n low with s_valid=1 → all outputs at reset values; first beat accepted only after rst_n high.
- Single sample, stub core_out=core_a[1]&core_b[0], beats 2,1,0,3, s_last=1, m_ready=1 → m_valid two cycles after d beat, m_class=1, m_idx=0; next cycle sum_valid=1, sum_pos=1, sum_total=1.
- Full batch BATCH_LEN=16, no s_last, alternating class → m_idx 0..15, one sum_valid after 16th handshake, sum_pos=8, sum_total=16, counters restart at 0.
- Backpressure: m_ready low 10 cycles in OUT → m_valid/m_class/m_idx stable, s_ready=0, no extra beats taken; release → single handshake.
- s_last on beat b → err=1 stays set, batch not ended at that sample; clear → err=0, state COLLECT.
- clear coincident with result handshake → result dropped, pos/total stay 0, no sum_valid.

Source files
------------

// File: rtl/tnn_sample_sequencer.sv
// Feeds a combinational classifier core from a 4-beat serial feature stream,
// returns each class bit over valid/ready and keeps per-batch positive/total counts.
module tnn_sample_sequencer #(
  parameter int FEAT_W    = 2,
  parameter int BATCH_LEN = 16,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic [FEAT_W-1:0] core_a,
  output logic [FEAT_W-1:0] core_b,
  output logic [FEAT_W-1:0] core_c,
  output logic [FEAT_W-1:0] core_d,
  input  logic              core_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_class,
  output logic [CNT_W-1:0]  m_idx,
  output logic              sum_valid,
  output logic [CNT_W-1:0]  sum_pos,
  output logic [CNT_W-1:0]  sum_total,
  output logic              err,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  // Handshakes: a beat or result transfers on the rising edge where valid and
  // ready are both high; valid never depends on ready, and clear drops the transfer.
  typedef enum logic [1:0] {COLLECT = 2'd0, EVAL = 2'd1, OUT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] BATCH_END = CNT_W'(BATCH_LEN);

  state_t           state, state_next;
  logic [1:0]       beat_cnt;
  logic             last_q;
  logic [CNT_W-1:0] pos_cnt, total_cnt;
  logic [CNT_W-1:0] pos_next, total_next;
  logic             s_fire, m_fire, batch_end;

  assign s_ready    = (state == COLLECT);
  assign m_valid    = (state == OUT);
  assign m_idx      = total_cnt;
  assign busy       = (state != COLLECT) || (beat_cnt != 2'd0);
  assign fsm_state  = state;
  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;
  assign pos_next   = pos_cnt + {{(CNT_W-1){1'b0}}, m_class};
  assign total_next = total_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign batch_end  = last_q || (total_next == BATCH_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (s_fire && beat_cnt == 2'd3) state_next = EVAL;
      EVAL:    state_next = OUT;
      OUT:     if (m_fire) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
    if (clear) state_next = COLLECT;
  end

  // Core inputs survive clear so the core output stays quiet across a soft clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_a <= '0;
      core_b <= '0;
      core_c <= '0;
      core_d <= '0;
    end else if (s_fire && !clear) begin
      case (beat_cnt)
        2'd0:    core_a <= s_data;
        2'd1:    core_b <= s_data;
        2'd2:    core_c <= s_data;
        default: core_d <= s_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      last_q    <= 1'b0;
      m_class   <= 1'b0;
      pos_cnt   <= '0;
      total_cnt <= '0;
      sum_valid <= 1'b0;
      sum_pos   <= '0;
      sum_total <= '0;
      err       <= 1'b0;
    end else if (clear) begin
      beat_cnt  <= '0;
      last_q    <= 1'b0;
      pos_cnt   <= '0;
      total_cnt <= '0;
      sum_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (s_fire) begin
        beat_cnt <= beat_cnt + 2'd1;
        if (beat_cnt == 2'd3) last_q <= s_last;
        else if (s_last)      err    <= 1'b1;
      end
      if (state == EVAL) m_class <= core_out;
      if (m_fire) begin
        if (batch_end) begin
          sum_valid <= 1'b1;
          sum_pos   <= pos_next;
          sum_total <= total_next;
          pos_cnt   <= '0;
          total_cnt <= '0;
        end else begin
          pos_cnt   <= pos_next;
          total_cnt <= total_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_tnn_sample_sequencer.sv
// Directed bench for tnn_sample_sequencer with a stub core (a[1] & b[0]).
module tb_tnn_sample_sequencer;

  localparam int FEAT_W = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [FEAT_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic [FEAT_W-1:0] core_a, core_b, core_c, core_d;
  logic              core_out;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_class;
  logic [CNT_W-1:0]  m_idx;
  logic              sum_valid;
  logic [CNT_W-1:0]  sum_pos, sum_total;
  logic              err, busy;
  logic [1:0]        fsm_state;

  int errors = 0;
  int checks = 0;

  tnn_sample_sequencer #(.FEAT_W(FEAT_W), .BATCH_LEN(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .core_out(core_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_idx(m_idx),
    .sum_valid(sum_valid), .sum_pos(sum_pos), .sum_total(sum_total),
    .err(err), .busy(busy), .fsm_state(fsm_state)
  );

  assign core_out = core_a[1] & core_b[0];

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [FEAT_W-1:0] data, input logic last);
    bit done = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      if (s_ready) done = 1;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL beat_accept: s_ready never seen, required 1");
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // One full sample with m_ready already high: EVAL, OUT, handshake.
  task automatic do_sample(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                           input logic [1:0] d, input logic last, input logic exp_class,
                           input int exp_idx, input logic exp_end, input int exp_pos,
                           input int exp_tot);
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
    send_beat(d, last);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL eval_cycle: m_valid=%b s_ready=%b busy=%b required 0 0 1", m_valid, s_ready, busy);
    end
    checks++;
    if ({core_a, core_b, core_c, core_d} !== {a, b, c, d}) begin
      errors++;
      $display("FAIL core_inputs: got %h required %h", {core_a, core_b, core_c, core_d}, {a, b, c, d});
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_class !== exp_class || m_idx !== CNT_W'(exp_idx)) begin
      errors++;
      $display("FAIL result: m_valid=%b m_class=%b m_idx=%0d required 1 %b %0d",
               m_valid, m_class, m_idx, exp_class, exp_idx);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || sum_valid !== exp_end) begin
      errors++;
      $display("FAIL after_handshake: m_valid=%b s_ready=%b sum_valid=%b required 0 1 %b",
               m_valid, s_ready, sum_valid, exp_end);
    end
    if (exp_end) begin
      checks++;
      if (sum_pos !== CNT_W'(exp_pos) || sum_total !== CNT_W'(exp_tot) || m_idx !== '0) begin
        errors++;
        $display("FAIL summary: pos=%0d total=%0d m_idx=%0d required %0d %0d 0",
                 sum_pos, sum_total, m_idx, exp_pos, exp_tot);
      end
    end else begin
      checks++;
      if (m_idx !== CNT_W'(exp_idx + 1)) begin
        errors++;
        $display("FAIL idx_advance: m_idx=%0d required %0d", m_idx, exp_idx + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 2'd3;
    repeat (3) tick();
    checks++;
    if (s_ready !== 1'b1 || {core_a, core_b, core_c, core_d} !== 8'h00 || m_valid !== 1'b0 ||
        m_class !== 1'b0 || m_idx !== '0 || sum_valid !== 1'b0 || sum_pos !== '0 ||
        sum_total !== '0 || err !== 1'b0 || busy !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: s_ready=%b core=%h m_valid=%b busy=%b err=%b state=%0d",
               s_ready, {core_a, core_b, core_c, core_d}, m_valid, busy, err, fsm_state);
    end
    s_valid = 1'b0;
    rst_n   = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || core_a !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b core_a=%0d required 0 0", busy, core_a);
    end
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    do_sample(2'd2, 2'd1, 2'd0, 2'd3, 1'b1, 1'b1, 0, 1'b1, 1, 1);
    tick();
    checks++;
    if (sum_valid !== 1'b0 || sum_pos !== 8'd1 || sum_total !== 8'd1) begin
      errors++;
      $display("FAIL summary_hold: sum_valid=%b pos=%0d total=%0d required 0 1 1",
               sum_valid, sum_pos, sum_total);
    end
  endtask

  task automatic test_full_batch();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        do_sample(2'd2, 2'd1, 2'(i), 2'(i >> 2), 1'b0, 1'b1, i, i == 15, 8, 16);
      else
        do_sample(2'd1, 2'd3, 2'(i), 2'(i >> 2), 1'b0, 1'b0, i, i == 15, 8, 16);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    send_beat(2'd3, 1'b0);
    send_beat(2'd3, 1'b0);
    send_beat(2'd2, 1'b0);
    send_beat(2'd1, 1'b0);
    tick();
    s_valid = 1'b1;
    s_data  = 2'd0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_class !== 1'b1 || m_idx !== '0 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_out[%0d]: m_valid=%b m_class=%b m_idx=%0d s_ready=%b required 1 1 0 0",
                 i, m_valid, m_class, m_idx, s_ready);
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || m_idx !== 8'd1 || sum_valid !== 1'b0 || core_a !== 2'd3) begin
      errors++;
      $display("FAIL release: m_valid=%b m_idx=%0d sum_valid=%b core_a=%0d required 0 1 0 3",
               m_valid, m_idx, sum_valid, core_a);
    end
  endtask

  task automatic test_partial_stall();
    clear_pulse();
    m_ready = 1'b1;
    send_beat(2'd1, 1'b0);
    send_beat(2'd2, 1'b0);
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL stall: busy=%b s_ready=%b state=%0d required 1 1 0", busy, s_ready, fsm_state);
    end
    send_beat(2'd3, 1'b0);
    send_beat(2'd0, 1'b1);
    checks++;
    if ({core_a, core_b, core_c, core_d} !== 8'b01_10_11_00) begin
      errors++;
      $display("FAIL stall_vector: got %h required 6c", {core_a, core_b, core_c, core_d});
    end
    tick();
    tick();
    checks++;
    if (sum_valid !== 1'b1 || sum_pos !== 8'd0 || sum_total !== 8'd1) begin
      errors++;
      $display("FAIL stall_summary: sum_valid=%b pos=%0d total=%0d required 1 0 1",
               sum_valid, sum_pos, sum_total);
    end
  endtask

  task automatic test_last_err();
    m_ready = 1'b1;
    send_beat(2'd0, 1'b0);
    send_beat(2'd0, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b required 1", err);
    end
    send_beat(2'd0, 1'b0);
    send_beat(2'd0, 1'b0);
    tick();
    tick();
    checks++;
    if (sum_valid !== 1'b0 || m_idx !== 8'd1 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_no_end: sum_valid=%b m_idx=%0d err=%b required 0 1 1", sum_valid, m_idx, err);
    end
    clear_pulse();
    checks++;
    if (err !== 1'b0 || fsm_state !== 2'd0 || m_idx !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b state=%0d m_idx=%0d busy=%b required 0 0 0 0",
               err, fsm_state, m_idx, busy);
    end
  endtask

  task automatic test_clear_handshake();
    m_ready = 1'b0;
    send_beat(2'd2, 1'b0);
    send_beat(2'd1, 1'b0);
    send_beat(2'd0, 1'b0);
    send_beat(2'd0, 1'b1);
    tick();
    m_ready = 1'b1;
    clear   = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || sum_valid !== 1'b0 || m_idx !== '0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL clear_drop: m_valid=%b sum_valid=%b m_idx=%0d state=%0d required 0 0 0 0",
               m_valid, sum_valid, m_idx, fsm_state);
    end
    tick();
    checks++;
    if (sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_sum: sum_valid=%b required 0", sum_valid);
    end
    do_sample(2'd2, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 0, 1'b1, 1, 1);
  endtask

  task automatic test_reset_mid_out();
    m_ready = 1'b0;
    send_beat(2'd2, 1'b0);
    send_beat(2'd1, 1'b0);
    send_beat(2'd1, 1'b0);
    send_beat(2'd1, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_class !== 1'b0 || core_a !== 2'd0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_out: m_valid=%b m_class=%b core_a=%0d s_ready=%b required 0 0 0 1",
               m_valid, m_class, core_a, s_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_batch();
    test_backpressure();
    test_partial_stall();
    test_last_err();
    test_clear_handshake();
    test_reset_mid_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
